aes_stream_buffer: RTL and testbench

//  Parametrised valid/ready front end for an AES core with fixed latency.

---
 rtl/aes_buf_pkg.sv | 31 +++
 rtl/aes_sync_fifo.sv | 86 ++++++++
 rtl/aes_stream_buffer.sv | 162 ++++++++++++++++
 tb/tb_aes_stream_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_buf_pkg.sv
// -----------------------------------------------------------------------------
// aes_buf_pkg
// Shared types and defaults for the AES stream buffer.
//   aes_req_t    : {blk, key} request record at default widths
//   aes_rsp_t    : {ct, keyout} response record at default widths
//   *_DEF        : default parameter values for aes_stream_buffer
//   aes_key_w_ok : true for the legal AES key widths (128/192/256)
// -----------------------------------------------------------------------------
package aes_buf_pkg;

  localparam int BLK_W_DEF     = 128;
  localparam int KEY_W_DEF     = 128;
  localparam int IN_DEPTH_DEF  = 4;
  localparam int OUT_DEPTH_DEF = 4;
  localparam int CORE_LAT_DEF  = 10;

  typedef struct packed {
    logic [BLK_W_DEF-1:0] blk;
    logic [KEY_W_DEF-1:0] key;
  } aes_req_t;

  typedef struct packed {
    logic [BLK_W_DEF-1:0] ct;
    logic [KEY_W_DEF-1:0] keyout;
  } aes_rsp_t;

  function automatic bit aes_key_w_ok(input int w);
    return (w == 128) || (w == 192) || (w == 256);
  endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// -----------------------------------------------------------------------------
// aes_sync_fifo
// Single-clock FIFO, power-of-two DEPTH, asynchronous active-high reset.
// A write on a full FIFO is accepted when a read happens in the same cycle,
// so occupancy stays unchanged. Read data is the head entry, forced to zero
// while empty.
// Ports:
//   clk, rst   : clock, async active-high reset
//   wr_en_i    : push request, wr_data_i pushed data
//   rd_en_i    : pop request (ignored while empty)
//   rd_data_o  : head entry (0 when empty)
//   count_o    : occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module aes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_s, empty_s, do_wr_s, do_rd_s;

  assign full_s  = (cnt_q == CW'(DEPTH));
  assign empty_s = (cnt_q == {CW{1'b0}});
  assign do_rd_s = rd_en_i && !empty_s;
  assign do_wr_s = wr_en_i && (!full_s || do_rd_s);

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_rd_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = empty_s ? {WIDTH{1'b0}} : mem_q[rptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/aes_stream_buffer.sv
// -----------------------------------------------------------------------------
// aes_stream_buffer
// Valid/ready front end for a fixed-latency AES core. Requests {plaintext,key}
// are queued, issued to the core up to one per cycle, and results
// {cipher_text,keyout} are queued and returned in order with backpressure.
// Issue is credit-checked against response FIFO space, so a core result is
// never dropped.
// Optional feature macro: AES_PERF_CNT_EN adds perf_done / perf_stall ports.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   in_valid/in_ready            : request handshake
//   in_plaintext, in_key         : request payload
//   core_start                   : one-cycle issue strobe to the core
//   core_plaintext, core_key     : head request, valid with core_start
//   core_cipher_text, core_keyout: core result, valid CORE_LAT cycles later
//   out_valid/out_ready          : response handshake
//   out_cipher_text, out_keyout  : head response
//   busy                         : anything buffered or in flight
//   perf_done, perf_stall        : (AES_PERF_CNT_EN) responses popped,
//                                  cycles with a request blocked by credit
// -----------------------------------------------------------------------------
module aes_stream_buffer
  import aes_buf_pkg::*;
#(
  parameter int BLK_W     = BLK_W_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int CORE_LAT  = CORE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_plaintext,
  input  logic [KEY_W-1:0] in_key,
  output logic             core_start,
  output logic [BLK_W-1:0] core_plaintext,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_cipher_text,
  input  logic [KEY_W-1:0] core_keyout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_cipher_text,
  output logic [KEY_W-1:0] out_keyout,
  output logic             busy
`ifdef AES_PERF_CNT_EN
  ,
  output logic [31:0]      perf_done,
  output logic [31:0]      perf_stall
`endif
);

  localparam int IW  = BLK_W + KEY_W;
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  if (!aes_key_w_ok(KEY_W)) begin : g_bad_key_w
    $error("aes_stream_buffer: KEY_W must be 128, 192 or 256");
  end

  logic [IW-1:0]       req_data_s, rsp_data_s;
  logic [ICW-1:0]      req_cnt_s;
  logic [OCW-1:0]      rsp_cnt_s;
  logic                req_empty_s, req_full_s, rsp_empty_s;
  logic                issue_s, capture_s, accept_s, pop_s;
  logic [OCW:0]        credit_use_s;
  logic [CORE_LAT-1:0] pipe_q, pipe_d;
  logic [OCW-1:0]      inflight_q, inflight_d;

  assign req_empty_s = (req_cnt_s == {ICW{1'b0}});
  assign req_full_s  = (req_cnt_s == ICW'(IN_DEPTH));
  assign rsp_empty_s = (rsp_cnt_s == {OCW{1'b0}});

  // in_ready is held low for the whole reset window, not just until the edge.
  assign in_ready = !rst && !req_full_s;
  assign accept_s = in_valid && in_ready;

  // Entries already captured plus those still in the core must fit in the
  // response FIFO before another block may be started.
  assign credit_use_s = {1'b0, rsp_cnt_s} + {1'b0, inflight_q};
  assign issue_s      = !req_empty_s && (credit_use_s < (OCW+1)'(OUT_DEPTH));
  assign capture_s    = pipe_q[CORE_LAT-1];
  assign pop_s        = out_valid && out_ready;

  aes_sync_fifo #(.WIDTH(IW), .DEPTH(IN_DEPTH)) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept_s),
    .wr_data_i ({in_plaintext, in_key}),
    .rd_en_i   (issue_s),
    .rd_data_o (req_data_s),
    .count_o   (req_cnt_s)
  );

  aes_sync_fifo #(.WIDTH(IW), .DEPTH(OUT_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (capture_s),
    .wr_data_i ({core_cipher_text, core_keyout}),
    .rd_en_i   (out_ready),
    .rd_data_o (rsp_data_s),
    .count_o   (rsp_cnt_s)
  );

  // Next state of the in-flight valid pipe and its population count.
  always_comb begin
    pipe_d     = (pipe_q << 1) | CORE_LAT'(issue_s);
    inflight_d = inflight_q;
    case ({issue_s, capture_s})
      2'b10:   inflight_d = inflight_q + OCW'(1);
      2'b01:   inflight_d = inflight_q - OCW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // In-flight tracking; clearing it on reset makes late core results vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q     <= {CORE_LAT{1'b0}};
      inflight_q <= {OCW{1'b0}};
    end else begin
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
    end
  end

  assign core_start      = issue_s;
  assign core_plaintext  = req_data_s[IW-1:KEY_W];
  assign core_key        = req_data_s[KEY_W-1:0];
  assign out_valid       = !rsp_empty_s;
  assign out_cipher_text = rsp_data_s[IW-1:KEY_W];
  assign out_keyout      = rsp_data_s[KEY_W-1:0];
  assign busy            = !req_empty_s || (inflight_q != {OCW{1'b0}}) || !rsp_empty_s;

`ifdef AES_PERF_CNT_EN
  logic [31:0] perf_done_q, perf_stall_q;

  // Performance counters; wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_done_q  <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (pop_s) begin
        perf_done_q <= perf_done_q + 32'd1;
      end
      // With a request waiting, the only thing that can block issue is credit.
      if (!req_empty_s && !issue_s) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_done  = perf_done_q;
  assign perf_stall = perf_stall_q;
`else
  logic unused_pop_s;
  assign unused_pop_s = pop_s;
`endif

endmodule

// File: tb/tb_aes_stream_buffer.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_buffer
// Directed bench for aes_stream_buffer with a stub core
// (ct = pt ^ key, keyout = ~key, CORE_LAT cycles later).
// Inputs change 1 ns after posedge; outputs are checked on negedge.
// A transaction-level model (queues of accepted requests/responses) is checked
// on every cycle by one monitor; directed checks pin latency and literals.
// -----------------------------------------------------------------------------
module tb_aes_stream_buffer;

  localparam int BLK_W     = 128;
  localparam int KEY_W     = 128;
  localparam int IN_DEPTH  = 2;
  localparam int OUT_DEPTH = 8;
  localparam int CORE_LAT  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [BLK_W-1:0] in_plaintext;
  logic [KEY_W-1:0] in_key;
  logic             core_start;
  logic [BLK_W-1:0] core_plaintext, core_cipher_text, out_cipher_text;
  logic [KEY_W-1:0] core_key, core_keyout, out_keyout;
  logic             out_valid, out_ready, busy;
`ifdef AES_PERF_CNT_EN
  logic [31:0]      perf_done, perf_stall;
`endif

  always #5 clk = ~clk;

  aes_stream_buffer #(
    .BLK_W(BLK_W), .KEY_W(KEY_W), .IN_DEPTH(IN_DEPTH),
    .OUT_DEPTH(OUT_DEPTH), .CORE_LAT(CORE_LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_plaintext     (in_plaintext),
    .in_key           (in_key),
    .core_start       (core_start),
    .core_plaintext   (core_plaintext),
    .core_key         (core_key),
    .core_cipher_text (core_cipher_text),
    .core_keyout      (core_keyout),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_cipher_text  (out_cipher_text),
    .out_keyout       (out_keyout),
    .busy             (busy)
`ifdef AES_PERF_CNT_EN
    ,
    .perf_done        (perf_done),
    .perf_stall       (perf_stall)
`endif
  );

  // Stub core: fixed-latency pipeline of pt^key / ~key.
  logic [BLK_W-1:0] sc_ct [CORE_LAT];
  logic [KEY_W-1:0] sc_ko [CORE_LAT];
  always @(posedge clk) begin
    sc_ct[0] <= core_plaintext ^ core_key;
    sc_ko[0] <= ~core_key;
    for (int j = 1; j < CORE_LAT; j++) begin
      sc_ct[j] <= sc_ct[j-1];
      sc_ko[j] <= sc_ko[j-1];
    end
  end
  assign core_cipher_text = sc_ct[CORE_LAT-1];
  assign core_keyout      = sc_ko[CORE_LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
  } pair_t;

  pair_t req_q[$];   // accepted, not yet issued
  pair_t exp_q[$];   // accepted, response not yet popped
  int    n_start = 0, n_pop = 0, run = 0, max_run = 0, stall_model = 0;
  bit    hold_v = 1'b0;
  pair_t held;

  // Monitor: check outputs against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    pair_t p;
    if (rst) begin
      req_q.delete();
      exp_q.delete();
      hold_v = 1'b0;
      run    = 0;
      chk("mon_rst_busy", busy, 0);
      chk("mon_rst_out_valid", out_valid, 0);
      chk("mon_rst_core_start", core_start, 0);
    end else begin
      chk("mon_busy", busy, (exp_q.size() != 0));
      if (out_valid && exp_q.size() == 0) chk("mon_spurious_out", out_valid, 0);
      if (core_start && req_q.size() == 0) chk("mon_spurious_start", core_start, 0);
      if (hold_v) begin
        chk("mon_hold_valid", out_valid, 1);
        chk("mon_hold_ct", out_cipher_text, held.a);
        chk("mon_hold_ko", out_keyout, held.b);
      end
      if (req_q.size() != 0 && !core_start) stall_model++;
      if (core_start && req_q.size() != 0) begin
        chk("mon_issue_pt", core_plaintext, req_q[0].a);
        chk("mon_issue_key", core_key, req_q[0].b);
        void'(req_q.pop_front());
        n_start++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("mon_rsp_ct", out_cipher_text, exp_q[0].a);
        chk("mon_rsp_ko", out_keyout, exp_q[0].b);
        void'(exp_q.pop_front());
        n_pop++;
      end
      hold_v = out_valid && !out_ready;
      held.a = out_cipher_text;
      held.b = out_keyout;
      if (in_valid && in_ready) begin
        p.a = in_plaintext;
        p.b = in_key;
        req_q.push_back(p);
        p.a = in_plaintext ^ in_key;
        p.b = ~in_key;
        exp_q.push_back(p);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_pt(input int i);
    return {4{32'h1000_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] mk_key(input int i);
    return {4{32'hC0DE_0000 ^ (32'(i) * 32'd7)}};
  endfunction

  task automatic send_burst(input int n, input int base);
    int i = 0;
    int g = 0;
    bit acc;
    while (i < n && g < 200) begin
      in_valid     = 1'b1;
      in_plaintext = mk_pt(base + i);
      in_key       = mk_key(base + i);
      acc          = in_ready;
      tick();
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    chk("burst_accepts", i, n);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int k, s0, p0, late, sm0;
    logic [127:0] pt1, key1;
`ifdef AES_PERF_CNT_EN
    logic [31:0] pd0, ps0;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_plaintext = '0; in_key = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_pt", core_plaintext, 0);
    chk("rst_out_ct", out_cipher_text, 0);
    chk("rst_out_ko", out_keyout, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // 1: single request, latency and stub-core result literals
    pt1  = 128'h00112233445566778899aabbccddeeff;
    key1 = 128'h000102030405060708090a0b0c0d0e0f;
    out_ready = 1'b1;
    in_plaintext = pt1; in_key = key1; in_valid = 1'b1;
    tick();                       // edge t accepts
    in_valid = 1'b0;
    chk("t1_core_start", core_start, 1);
    chk("t1_core_pt", core_plaintext, pt1);
    chk("t1_core_key", core_key, key1);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk("t1_latency_edges", k, 5);
    chk("t1_ct", out_cipher_text, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("t1_keyout", out_keyout, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    tick();
    chk("t1_busy_fall", busy, 0);
    chk("t1_out_valid_fall", out_valid, 0);

    // 2: 16 back-to-back requests, unstalled
    max_run = 0; p0 = n_pop;
    send_burst(16, 100);
    wait_idle(100);
    chk("t2_start_run", max_run, 16);
    chk("t2_pops", n_pop - p0, 16);

    // 3: consumer stalled, 10 requests -> credit and request FIFO fill
    out_ready = 1'b0; s0 = n_start; p0 = n_pop; sm0 = stall_model;
`ifdef AES_PERF_CNT_EN
    pd0 = perf_done; ps0 = perf_stall;
`endif
    send_burst(10, 200);
    chk("t3_in_ready_full", in_ready, 0);
    repeat (12) tick();
    chk("t3_starts", n_start - s0, OUT_DEPTH);
    chk("t3_in_ready_still", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_core_start_blocked", core_start, 0);

    // 4: drain; captures land while the response FIFO is near full
    out_ready = 1'b1;
    wait_idle(100);
    chk("t4_pops", n_pop - p0, 10);
    chk("t4_out_valid", out_valid, 0);
`ifdef AES_PERF_CNT_EN
    chk("t6_perf_done_delta", perf_done - pd0, 10);
    chk("t6_perf_done_abs", perf_done, 27);
    chk("t6_perf_stall", perf_stall - ps0, 32'(stall_model - sm0));
`else
    chk("t3_stall_cycles_seen", (stall_model - sm0) > 0, 1);
`endif

    // 5: reset with 3 in flight and 2 buffered
    out_ready = 1'b0;
    send_burst(5, 300);
    repeat (10) tick();
    send_burst(5, 400);
    chk("t5_in_full", in_ready, 0);
    chk("t5_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    late = 0;
    repeat (12) begin
      tick();
      if (out_valid) late++;
    end
    chk("t5_no_late_rsp", late, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
